buzz_arbiter: RTL

BUZZ_ARBITER -- requirements
Module: buzz_arbiter

---
 rtl/buzz_arbiter.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/buzz_arbiter.sv
// Quiz-show buzzer arbiter: synchronised, debounced player buttons, first press locks the round.
// Define FOUL_DETECT_EN to flag players who press before arming and exclude them from the round.
module buzz_arbiter #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned TICK_DIV        = 10,
    parameter logic [7:0]  ANSWER_TIME     = 8'h15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] player_btn,
    input  logic       host_start,
    input  logic       host_clear,
    output logic [3:0] winner_id,
    output logic [7:0] timer_bcd,
    output logic [1:0] arb_state,
    output logic       timeout_pulse,
    output logic [3:0] foul_mask
);

    localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StArmed   = 2'b01,
        StLocked  = 2'b10,
        StTimeout = 2'b11
    } state_e;

    state_e state_q, state_d;

    logic [3:0]       sync1_q, sync2_q;
    logic [3:0]       db_q, db_prev_q;
    logic [DbW-1:0]   db_cnt_q [4];
    logic [3:0]       press, eligible;
    logic [TickW-1:0] tick_q, tick_d;
    logic [7:0]       timer_q, timer_d, timer_dec;
    logic [3:0]       winner_q, winner_d;
    logic             pulse_q;
    logic             tick_wrap, expire;

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0) begin
            return {v[7:4] - 4'd1, 4'd9};
        end
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    function automatic logic [3:0] first_player(input logic [3:0] ev);
        logic [3:0] id;
        id = 4'd0;
        for (int i = 3; i >= 0; i--) begin
            if (ev[i]) id = 4'(i + 1);
        end
        return id;
    endfunction

    // Level flips only after DEBOUNCE_CYCLES consecutive samples that disagree with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q   <= player_btn;
            sync2_q   <= sync1_q;
            db_prev_q <= db_q;
            for (int i = 0; i < 4; i++) begin
                if (sync2_q[i] == db_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DbLast) begin
                    db_q[i]     <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign press = db_q & ~db_prev_q;

`ifdef FOUL_DETECT_EN
    logic [3:0] foul_q, foul_d;

    always_comb begin
        foul_d = foul_q;
        if (host_clear) begin
            if (state_q == StIdle) foul_d = '0;
        end else if (state_q == StIdle) begin
            foul_d = foul_q | press;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) foul_q <= '0;
        else     foul_q <= foul_d;
    end

    assign eligible  = press & ~foul_q;
    assign foul_mask = foul_q;
`else
    assign eligible  = press;
    assign foul_mask = '0;
`endif

    assign tick_wrap = (tick_q == TickLast);
    assign timer_dec = (timer_q == 8'h00) ? 8'h00 : bcd_dec(timer_q);
    assign expire    = tick_wrap && (timer_dec == 8'h00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pulse_q <= (state_q == StArmed) && (state_d == StTimeout);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (host_start) state_d = StArmed;
            end
            StArmed: begin
                if (host_start)     state_d = StArmed;
                else if (|eligible) state_d = StLocked;
                else if (expire)    state_d = StTimeout;
            end
            StLocked, StTimeout: state_d = state_q;
        endcase
        if (host_clear) state_d = StIdle;
    end

    always_comb begin
        arb_state     = state_q;
        winner_id     = winner_q;
        timer_bcd     = timer_q;
        timeout_pulse = pulse_q;
    end

    // A press in the same cycle as a decrement still sees the decremented time frozen.
    always_comb begin
        tick_d   = tick_q;
        timer_d  = timer_q;
        winner_d = winner_q;
        unique case (state_q)
            StIdle: begin
                tick_d   = '0;
                timer_d  = host_start ? ANSWER_TIME : 8'h00;
                winner_d = 4'd0;
            end
            StArmed: begin
                if (host_start) begin
                    tick_d  = '0;
                    timer_d = ANSWER_TIME;
                end else begin
                    if (tick_wrap) begin
                        tick_d  = '0;
                        timer_d = timer_dec;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                    if (|eligible) winner_d = first_player(eligible);
                end
            end
            StLocked, StTimeout: ;
        endcase
        if (host_clear) begin
            tick_d   = '0;
            timer_d  = 8'h00;
            winner_d = 4'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q   <= '0;
            timer_q  <= 8'h00;
            winner_q <= 4'd0;
        end else begin
            tick_q   <= tick_d;
            timer_q  <= timer_d;
            winner_q <= winner_d;
        end
    end

endmodule
